// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the FP unit arbiter: tag format, tag width, one-hot encode.
package fp_arb_pkg;

    localparam int unsigned MAX_NREQ = 256;
    localparam int unsigned MAX_TAGW = 8;

    // Index field is sized for the largest supported NREQ; unused upper bits stay zero.
    typedef struct packed {
        logic                valid;
        logic [MAX_TAGW-1:0] idx;
    } tag_t;

    function automatic int unsigned calc_tagw(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic [MAX_TAGW-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] onehot);
        logic [MAX_TAGW-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_NREQ); i++) begin
            if (onehot[i]) idx = idx | MAX_TAGW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fp_tag_delay.sv
// Depth-D shift register of requester tags matching the shared FP unit latency.
module fp_tag_delay
    import fp_arb_pkg::*;
#(
    parameter int unsigned D = 1
) (
    input  logic clock,
    input  logic clock_sreset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    logic [D-1:0]        valid_q;
    logic [MAX_TAGW-1:0] idx_q [D];

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= tag_in.valid;
            for (int i = 1; i < int'(D); i++) valid_q[i] <= valid_q[i-1];
        end
    end

    // Index bits have no reset; they only matter alongside a set valid bit.
    always_ff @(posedge clock) begin
        idx_q[0] <= tag_in.idx;
        for (int i = 1; i < int'(D); i++) idx_q[i] <= idx_q[i-1];
    end

    always_comb begin
        tag_out.valid = valid_q[D-1];
        tag_out.idx   = idx_q[D-1];
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one fixed-latency FP unit among NREQ requesters and routes results back by tag.
// Define FP_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned EXP     = 8,
    parameter int unsigned MANT    = 9,
    parameter int unsigned WIDTH   = 1 + EXP + MANT,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LCYCLES = 2
) (
    input  logic                          clock,
    input  logic                          clock_sreset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0]    req_dataa,
    input  logic [NREQ-1:0][WIDTH-1:0]    req_datab,
    output logic [NREQ-1:0]               req_ready,
    output logic                          fu_valid,
    output logic [WIDTH-1:0]              fu_dataa,
    output logic [WIDTH-1:0]              fu_datab,
    input  logic                          fu_result_valid,
    input  logic [WIDTH-1:0]              fu_result,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [WIDTH-1:0]              rsp_result,
    output logic [$clog2(LCYCLES+3)-1:0]  inflight,
    output logic                          err
);

    localparam int unsigned TAGW = calc_tagw(NREQ);
    localparam int unsigned IFW  = $clog2(LCYCLES + 3);

    logic [NREQ-1:0]  grant;
    logic             grant_any;
    logic [TAGW-1:0]  grant_idx;

    logic             fu_valid_q;
    logic [WIDTH-1:0] fu_dataa_q, fu_dataa_d;
    logic [WIDTH-1:0] fu_datab_q, fu_datab_d;
    logic [IFW-1:0]   inflight_q, inflight_d;
    logic             err_q, err_d;

    tag_t             tag_in;
    tag_t             tag_out;
    logic             rsp_fire;

`ifdef FP_ARB_RR_EN
    logic [TAGW-1:0] ptr_q, ptr_d;

    // Two passes: indices above the pointer first, then wrap to 0..pointer.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req_valid[i] && (i > int'(ptr_q))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req_valid[i] && (i <= int'(ptr_q))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign ptr_d = grant_any ? grant_idx : ptr_q;

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            ptr_q <= TAGW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    assign grant_any = |grant;
    assign grant_idx = TAGW'(onehot_to_idx(MAX_NREQ'(grant)));
    assign req_ready = grant;

    always_comb begin
        fu_dataa_d = fu_dataa_q;
        fu_datab_d = fu_datab_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                fu_dataa_d = req_dataa[i];
                fu_datab_d = req_datab[i];
            end
        end
    end

    always_comb begin
        tag_in.valid = grant_any;
        tag_in.idx   = MAX_TAGW'(grant_idx);
    end

    fp_tag_delay #(
        .D (LCYCLES + 1)
    ) u_tag_delay (
        .clock        (clock),
        .clock_sreset (clock_sreset),
        .tag_in       (tag_in),
        .tag_out      (tag_out)
    );

    // A strobe/tag disagreement delivers nothing and is latched in err.
    assign rsp_fire   = fu_result_valid & tag_out.valid;
    assign rsp_valid  = rsp_fire ? (NREQ'(1) << tag_out.idx) : '0;
    assign rsp_result = fu_result;
    assign err_d      = err_q | (fu_result_valid != tag_out.valid);

    always_comb begin
        inflight_d = inflight_q;
        case ({grant_any, rsp_fire})
            2'b10:   inflight_d = inflight_q + IFW'(1);
            2'b01:   inflight_d = inflight_q - IFW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            fu_valid_q <= 1'b0;
            fu_dataa_q <= '0;
            fu_datab_q <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            fu_valid_q <= grant_any;
            fu_dataa_q <= fu_dataa_d;
            fu_datab_q <= fu_datab_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign fu_valid = fu_valid_q;
    assign fu_dataa = fu_dataa_q;
    assign fu_datab = fu_datab_q;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Scoreboard bench for fp_unit_arbiter with a behavioural shared-FP-unit pipeline.
module tb_fp_unit_arbiter;

    localparam int unsigned EXP     = 8;
    localparam int unsigned MANT    = 9;
    localparam int unsigned WIDTH   = 1 + EXP + MANT;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned LCYCLES = 2;
    localparam int unsigned IFW     = $clog2(LCYCLES + 3);

    logic                       clock = 1'b0;
    logic                       clock_sreset;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][WIDTH-1:0] req_dataa;
    logic [NREQ-1:0][WIDTH-1:0] req_datab;
    logic [NREQ-1:0]            req_ready;
    logic                       fu_valid;
    logic [WIDTH-1:0]           fu_dataa;
    logic [WIDTH-1:0]           fu_datab;
    logic                       fu_result_valid;
    logic [WIDTH-1:0]           fu_result;
    logic [NREQ-1:0]            rsp_valid;
    logic [WIDTH-1:0]           rsp_result;
    logic [IFW-1:0]             inflight;
    logic                       err;
    logic                       spurious;

    fp_unit_arbiter #(
        .EXP     (EXP),
        .MANT    (MANT),
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .LCYCLES (LCYCLES)
    ) dut (
        .clock           (clock),
        .clock_sreset    (clock_sreset),
        .req_valid       (req_valid),
        .req_dataa       (req_dataa),
        .req_datab       (req_datab),
        .req_ready       (req_ready),
        .fu_valid        (fu_valid),
        .fu_dataa        (fu_dataa),
        .fu_datab        (fu_datab),
        .fu_result_valid (fu_result_valid),
        .fu_result       (fu_result),
        .rsp_valid       (rsp_valid),
        .rsp_result      (rsp_result),
        .inflight        (inflight),
        .err             (err)
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] fu_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return WIDTH'(a * 3 + b);
    endfunction

    // Shared FP unit model: LCYCLES-cycle pipeline, reset by the same reset.
    logic [WIDTH:0] fu_pipe [LCYCLES+2];
    logic [WIDTH:0] fu_tail;

    always @(posedge clock) begin
        if (clock_sreset) begin
            for (int i = 0; i < int'(LCYCLES) + 2; i++) fu_pipe[i] <= '0;
        end else begin
            fu_pipe[1] <= {fu_valid, fu_op(fu_dataa, fu_datab)};
            for (int i = 2; i <= int'(LCYCLES); i++) fu_pipe[i] <= fu_pipe[i-1];
        end
    end

    assign fu_tail = (LCYCLES == 0) ? {fu_valid, fu_op(fu_dataa, fu_datab)} : fu_pipe[LCYCLES];
    assign fu_result_valid = fu_tail[WIDTH] | spurious;
    assign fu_result = fu_tail[WIDTH-1:0];

    typedef struct {
        int               due;
        int               idx;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t             q[$];
    int               cyc = 0;
    int               tests = 0;
    int               fails = 0;
    bit               mon_en = 1'b0;
    int               last_grant;
    logic             exp_fu_valid;
    logic [WIDTH-1:0] exp_fu_a;
    logic [WIDTH-1:0] exp_fu_b;
    logic             exp_err;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
`ifdef FP_ARB_RR_EN
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
`else
        for (int c = 0; c < int'(NREQ); c++) begin
            if (v[c]) return c;
        end
`endif
        return -1;
    endfunction

    // One cycle of stimulus; entered #1 after a rising edge, leaves #1 after the next one.
    task automatic step(input logic [NREQ-1:0] v, input logic spur);
        int g;
        req_valid = v;
        spurious  = spur;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_dataa[i] = WIDTH'($urandom);
            req_datab[i] = WIDTH'($urandom);
        end
        @(negedge clock);
        check("fu_valid", fu_valid, exp_fu_valid);
        check("fu_dataa", fu_dataa, exp_fu_a);
        check("fu_datab", fu_datab, exp_fu_b);
        check("err", err, exp_err);
        g = model_pick(v, last_grant);
        check("req_ready", req_ready, (g >= 0) ? (NREQ'(1) << g) : NREQ'(0));
        if (g >= 0) begin
            q.push_back('{due: cyc + 1 + int'(LCYCLES), idx: g,
                          res: fu_op(req_dataa[g], req_datab[g])});
            last_grant   = g;
            exp_fu_valid = 1'b1;
            exp_fu_a     = req_dataa[g];
            exp_fu_b     = req_datab[g];
        end else begin
            exp_fu_valid = 1'b0;
        end
        if (spur) exp_err = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        last_grant   = int'(NREQ) - 1;
        exp_fu_valid = 1'b0;
        exp_fu_a     = '0;
        exp_fu_b     = '0;
        exp_err      = 1'b0;
    endtask

    task automatic do_reset();
        req_valid    = '0;
        spurious     = 1'b0;
        clock_sreset = 1'b1;
        @(posedge clock);
        #1;
        clock_sreset = 1'b0;
        model_reset();
    endtask

    // Monitor: in-flight count and result delivery against the scoreboard.
    initial begin
        int   n;
        exp_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                n = 0;
                foreach (q[j]) if (q[j].due <= cyc + int'(LCYCLES)) n++;
                check("inflight", inflight, n);
                if (rsp_valid != '0) begin
                    if (q.size() == 0) begin
                        check("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        e = q.pop_front();
                        check("rsp_cycle", cyc, e.due);
                        check("rsp_valid", rsp_valid, NREQ'(1) << e.idx);
                        check("rsp_result", rsp_result, e.res);
                    end
                end else if (q.size() != 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    check("missing_rsp", rsp_valid, NREQ'(1) << e.idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", tests);
        $fatal(1);
    end

    initial begin
        clock_sreset = 1'b1;
        req_valid    = '0;
        req_dataa    = '0;
        req_datab    = '0;
        spurious     = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        clock_sreset = 1'b0;
        mon_en = 1'b1;

        repeat (2) step('0, 1'b0);

        step(4'b0100, 1'b0);
        repeat (LCYCLES + 3) step('0, 1'b0);

        repeat (12) step(4'b1111, 1'b0);
        repeat (LCYCLES + 3) step('0, 1'b0);

        for (int i = 0; i < 8; i++) step((i % 2) ? 4'b0100 : 4'b0010, 1'b0);
        repeat (LCYCLES + 3) step('0, 1'b0);

        repeat (300) step(NREQ'($urandom), 1'b0);
        repeat (LCYCLES + 3) step('0, 1'b0);

        step('0, 1'b1);
        repeat (4) step('0, 1'b0);
        do_reset();
        repeat (3) step('0, 1'b0);

        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        do_reset();
        repeat (LCYCLES + 3) step('0, 1'b0);

        repeat (100) step(NREQ'($urandom), 1'b0);
        repeat (LCYCLES + 3) step('0, 1'b0);

        check("drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
